// File: rtl/mem_arbiter_pkg.sv
// Shared CPU-side bus definitions: arbiter state encodings and master indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  // Master indices; the last-served pointer holds one of these.
  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    GNT0 = ST_GNT0,
    GNT1 = ST_GNT1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Cycle counter for a granted access; flags the cycle in which the wait limit is hit.
// Latency: o_expired is combinational on the TIMEOUT-th enabled cycle after a clear.
// Backpressure: none; counts while enabled, holds at the limit.
module bus_timeout
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter holds the number of enabled cycles already completed, so the
  // current cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
  assign o_expired = i_enable && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next count: clear wins, otherwise advance while enabled and not at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !o_expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one shared memory slave bus, with access timeout.
// Latency: grant one cycle after cs; slave signals pass through combinationally while granted.
// Backpressure: losing master waits with ack=0; one idle cycle is forced between accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  input  logic        i_m0_cs,
  input  logic        i_m0_we,
  output logic [15:0] o_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  input  logic        i_m1_cs,
  input  logic        i_m1_we,
  output logic [15:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_dat,
  output logic        o_mem_cs,
  output logic        o_mem_we,
  input  logic [15:0] i_mem_dat,
  input  logic        i_mem_ack
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       expired;
  logic       granted;
  logic       sel;
  logic       sel_cs;
  logic       done_ack;
  logic       done_err;

  assign granted = (state_q == GNT0) || (state_q == GNT1);
  assign sel     = (state_q == GNT1) ? MST_DMA : MST_CPU;
  assign sel_cs  = (sel == MST_DMA) ? i_m1_cs : i_m0_cs;

  // Read data is broadcast; only the ack tells a master the data is theirs.
  assign o_m0_dat = i_mem_dat;
  assign o_m1_dat = i_mem_dat;

  bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (!granted),
    .i_enable (granted),
    .o_expired(expired)
  );

  // Next-state, grant decode and slave-bus muxing.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    o_mem_addr = '0;
    o_mem_dat  = '0;
    o_mem_cs   = 1'b0;
    o_mem_we   = 1'b0;
    done_ack   = 1'b0;
    done_err   = 1'b0;

    if (state_q == IDLE) begin
      // On a tie, serve whichever master did not go last.
      if (i_m0_cs && (!i_m1_cs || last_q == MST_DMA)) begin
        state_d = GNT0;
        last_d  = MST_CPU;
      end else if (i_m1_cs) begin
        state_d = GNT1;
        last_d  = MST_DMA;
      end
    end else if (granted) begin
      o_mem_addr = (sel == MST_DMA) ? i_m1_addr : i_m0_addr;
      o_mem_dat  = (sel == MST_DMA) ? i_m1_dat  : i_m0_dat;
      o_mem_we   = (sel == MST_DMA) ? i_m1_we   : i_m0_we;
      if (!sel_cs) begin
        // Master abandoned the access: release the slave silently.
        state_d = IDLE;
      end else if (i_mem_ack) begin
        // Slave ack takes priority over a coincident timeout.
        o_mem_cs = 1'b1;
        done_ack = 1'b1;
        state_d  = IDLE;
      end else if (expired) begin
        done_ack = 1'b1;
        done_err = 1'b1;
        state_d  = IDLE;
      end else begin
        o_mem_cs = 1'b1;
      end
    end else begin
      state_d = IDLE;
    end

    // An access being reset is aborted without any completion to the master.
    if (i_reset) begin
      done_ack = 1'b0;
      done_err = 1'b0;
    end
  end

  assign o_m0_ack = done_ack && (sel == MST_CPU);
  assign o_m0_err = done_err && (sel == MST_CPU);
  assign o_m1_ack = done_ack && (sel == MST_DMA);
  assign o_m1_err = done_err && (sel == MST_DMA);

  // State and round-robin pointer; after reset the CPU wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= MST_DMA;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table plus randomized traffic against a reference model.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: slave ack is driven by the bench (fixed in the table, random afterwards).
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a0, d0, a1, d1, mdat;
  logic        cs0, we0, cs1, we1, mack;
  logic [15:0] m0_dat, m1_dat, mem_addr, mem_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err, mem_cs, mem_we;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (-1 none), how many cycles the current
  // access has lasted including this one, and who was served last.
  int m_owner;
  int m_age;
  int m_last;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_m0_addr (a0),
    .i_m0_dat  (d0),
    .i_m0_cs   (cs0),
    .i_m0_we   (we0),
    .o_m0_dat  (m0_dat),
    .o_m0_ack  (m0_ack),
    .o_m0_err  (m0_err),
    .i_m1_addr (a1),
    .i_m1_dat  (d1),
    .i_m1_cs   (cs1),
    .i_m1_we   (we1),
    .o_m1_dat  (m1_dat),
    .o_m1_ack  (m1_ack),
    .o_m1_err  (m1_err),
    .o_mem_addr(mem_addr),
    .o_mem_dat (mem_dat),
    .o_mem_cs  (mem_cs),
    .o_mem_we  (mem_we),
    .i_mem_dat (mdat),
    .i_mem_ack (mack)
  );

  typedef struct {
    logic        rst, cs0, we0, cs1, we1, mack;
    logic [15:0] mdat;
    logic        ecs;
    logic [15:0] eaddr;
    logic [3:0]  eae;   // {m0_ack, m0_err, m1_ack, m1_err}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic c0, input logic w0,
                              input logic c1, input logic w1, input logic mk_ack,
                              input logic [15:0] md, input logic ecs,
                              input logic [15:0] eaddr, input logic [3:0] eae);
    vec_t v;
    v.rst = r; v.cs0 = c0; v.we0 = w0; v.cs1 = c1; v.we1 = w1; v.mack = mk_ack;
    v.mdat = md; v.ecs = ecs; v.eaddr = eaddr; v.eae = eae;
    return v;
  endfunction

  // Expected {addr, dat, cs, we, ack0, err0, ack1, err1, m0_dat, m1_dat}.
  function automatic logic [69:0] model_out();
    logic [15:0] ad = '0;
    logic [15:0] dt = '0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  ae = '0;
    logic        own_cs;
    if (m_owner >= 0) begin
      own_cs = (m_owner == 0) ? cs0 : cs1;
      ad = (m_owner == 0) ? a0 : a1;
      dt = (m_owner == 0) ? d0 : d1;
      we = (m_owner == 0) ? we0 : we1;
      if (!own_cs) begin
        cs = 1'b0;
      end else if (mack) begin
        cs = 1'b1;
        ae = (m_owner == 0) ? 4'b1000 : 4'b0010;
      end else if (m_age == TO) begin
        cs = 1'b0;
        ae = (m_owner == 0) ? 4'b1100 : 4'b0011;
      end else begin
        cs = 1'b1;
      end
      if (rst) ae = '0;
    end
    return {ad, dt, cs, we, ae, mdat, mdat};
  endfunction

  task automatic model_step();
    logic own_cs;
    if (rst) begin
      m_owner = -1; m_age = 0; m_last = 1;
    end else if (m_owner < 0) begin
      if (cs0 && cs1) m_owner = 1 - m_last;
      else if (cs0)   m_owner = 0;
      else if (cs1)   m_owner = 1;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_age  = 1;
      end
    end else begin
      own_cs = (m_owner == 0) ? cs0 : cs1;
      if (!own_cs || mack || m_age == TO) begin
        m_owner = -1;
        m_age   = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  endtask

  // Called at the falling edge: compare against the model, advance it, move past the next rising edge.
  task automatic sample_and_advance(input string tag);
    logic [69:0] exp_v;
    logic [69:0] got_v;
    exp_v = model_out();
    got_v = {mem_addr, mem_dat, mem_cs, mem_we, m0_ack, m0_err, m1_ack, m1_err, m0_dat, m1_dat};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h", tag, got_v, exp_v);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cs0 = 0; we0 = 0; cs1 = 0; we1 = 0; mack = 0; mdat = '0;
    a0 = 16'h0010; d0 = 16'h5A5A; a1 = 16'h1234; d1 = 16'h00FF;
    m_owner = -1; m_age = 0; m_last = 1;
    repeat (2) @(posedge clk);
    #1;

    //                 rst cs0 we0 cs1 we1 ack mdat      ecs addr      {a0,e0,a1,e1}
    // Reset state, then CPU read acked after two granted cycles.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'hBEEF, 1, 16'h0010, 4'b1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    // Both requesting from reset: m0, m1, m0, m1 with an idle cycle between.
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 16'h1111, 1, 16'h0010, 4'b1000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 16'h2222, 1, 16'h1234, 4'b0010));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 16'h3333, 1, 16'h0010, 4'b1000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 16'h4444, 1, 16'h1234, 4'b0010));
    // m1 write never acked: timeout on the 4th granted cycle.
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0000, 1, 16'h1234, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0000, 1, 16'h1234, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0000, 1, 16'h1234, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h1234, 4'b0011));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    // Ack coincides with timeout: ack wins, no error.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'h5555, 1, 16'h0010, 4'b1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    // Reset pulse mid-grant, regrant once reset drops, then m0 abandons.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0010, 4'b0000));
    // m0 drops cs with m1 waiting; late slave ack in idle is ignored.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0010, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 16'h6666, 0, 16'h0000, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 1, 16'h1234, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 16'hC0DE, 1, 16'h1234, 4'b0010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; cs0 = tbl[i].cs0; we0 = tbl[i].we0;
      cs1 = tbl[i].cs1; we1 = tbl[i].we1; mack = tbl[i].mack; mdat = tbl[i].mdat;
      @(negedge clk);
      checks++;
      if ({mem_cs, mem_addr, m0_ack, m0_err, m1_ack, m1_err} !==
          {tbl[i].ecs, tbl[i].eaddr, tbl[i].eae}) begin
        errors++;
        $display("FAIL vec%0d: cs/addr/acks got %b/%h/%b required %b/%h/%b", i,
                 mem_cs, mem_addr, {m0_ack, m0_err, m1_ack, m1_err},
                 tbl[i].ecs, tbl[i].eaddr, tbl[i].eae);
      end
      sample_and_advance($sformatf("vec%0d_model", i));
    end

    // Randomized traffic: masters hold cs most of the time, slave acks sporadically.
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      cs0  = ($urandom_range(0, 9) < 6);
      cs1  = ($urandom_range(0, 9) < 6);
      we0  = 1'($urandom);
      we1  = 1'($urandom);
      a0   = 16'($urandom);
      d0   = 16'($urandom);
      a1   = 16'($urandom);
      d1   = 16'($urandom);
      mack = ($urandom_range(0, 9) < 3);
      mdat = 16'($urandom);
      @(negedge clk);
      sample_and_advance($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles a granted access waits for slave ack (range 1..255).
REQ-002 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports i_m0_addr/i_m0_dat  input  16 each  master 0 (CPU) address / write data.
REQ-005 SHALL have ports i_m0_cs/i_m0_we  input  1 each  master 0 chip select / write enable.
REQ-006 SHALL have ports o_m0_dat  output  16, o_m0_ack  output  1, o_m0_err  output  1  master 0 read data / ack / timeout error.
REQ-007 SHALL have ports i_m1_addr, i_m1_dat, i_m1_cs, i_m1_we, o_m1_dat, o_m1_ack, o_m1_err with widths identical to master 0 (master 1 = DMA/debug port).
REQ-008 SHALL have ports o_mem_addr  output  16, o_mem_dat  output  16, o_mem_cs  output  1, o_mem_we  output  1  shared slave bus.
REQ-009 SHALL have ports i_mem_dat  input  16, i_mem_ack  input  1  slave read data / ack.

Function
REQ-010 SHALL implement FSM with states IDLE, GNT0, GNT1; state register only, grant decoded from state.
REQ-011 IDLE: o_mem_cs=0, o_mem_we=0, o_mem_addr=0, o_mem_dat=0, both acks and errs 0.
REQ-012 IDLE -> GNTn on next edge when only i_mn_cs=1; grant latency exactly 1 cycle from cs assertion.
REQ-013 Both cs=1 in IDLE: grant master not served last (round-robin via 1-bit last pointer, updated on entering GNTn).
REQ-014 GNTn: o_mem_addr/dat/cs/we combinationally follow master n inputs; other master ignored.
REQ-015 o_mn_ack = i_mem_ack when state=GNTn, else 0; o_m0_dat and o_m1_dat both = i_mem_dat always.
REQ-016 GNTn with i_mem_ack=1: transaction complete, next state IDLE (one bubble cycle between accesses, mandatory).
REQ-017 SHALL count cycles in GNTn with 8-bit counter, cleared on entering GNTn and in IDLE.
REQ-018 Counter reaching TIMEOUT without ack: in that cycle o_mem_cs=0, o_mn_ack=1, o_mn_err=1 (one cycle), next state IDLE.
REQ-019 i_mem_ack and timeout in same cycle: ack wins, err=0.
REQ-020 Granted master drops cs before ack: o_mem_cs=0 that cycle, no ack/err, next state IDLE.
REQ-021 i_mem_ack while IDLE SHALL be ignored (no master ack).
REQ-022 Pending non-granted master SHALL wait with ack=0; worst-case wait bounded by one transaction + TIMEOUT + 2 cycles.

Reset
REQ-023 i_reset=1 SHALL force state IDLE, counter 0, last pointer = master 1 (CPU wins first tie) on next edge.
REQ-024 Reset mid-transaction SHALL abort it; outputs take REQ-011 values from the cycle after reset asserts, no ack/err emitted.

Structure
REQ-025 State encodings (IDLE, GNT0, GNT1) and master indices SHALL be localparams in a shared bus package used by CPU-side bus blocks.
REQ-026 Timeout counter SHALL be a sub-module bus_timeout (clear, enable, TIMEOUT parameter, expired output); rest flat.

Verification
REQ-027 m0 read addr 0x0010, mem acks after 2 cycles with 0xBEEF -> o_mem_cs one cycle after cs, o_m0_ack=1 with o_m0_dat=0xBEEF, o_m1_ack=0.
REQ-028 Both cs=1 from reset, each acked next cycle -> grants m0, m1, m0, m1 alternating, one IDLE cycle between.
REQ-029 m1 write addr 0x1234 data 0x00FF, no ack, TIMEOUT=4 -> o_m1_ack=o_m1_err=1 on 4th GNT1 cycle, o_mem_cs=0 then, IDLE next.
REQ-030 Ack and timeout coincide on count 4 -> o_m0_ack=1, o_m0_err=0.
REQ-031 i_reset pulsed during GNT0 with m0 cs held -> IDLE next cycle, no ack, regrant GNT0 one cycle after reset drops.
REQ-032 m0 drops cs in GNT0 before ack, m1 cs=1 -> IDLE, then GNT1; late i_mem_ack in IDLE produces no ack.
